// File: rtl/issue_queue_int.sv
// Integer issue queue: holds dispatched uops, asks the scoreboard whether each
// slot's sources are busy, and issues the oldest ready uops to the execute ports.
// Relative age is tracked with an age matrix: older_r[i][j] = slot i is older than j.
module issue_queue_int #(
    parameter int IQ_SIZE        = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int ISSUE_WIDTH    = 2,
    parameter int PRF_INDEX_SIZE = 6,
    parameter int UOP_WIDTH      = 64
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     clear,
    input  logic [DISPATCH_WIDTH-1:0]                dispatch_valid,
    input  logic [DISPATCH_WIDTH*PRF_INDEX_SIZE-1:0] dispatch_rs1,
    input  logic [DISPATCH_WIDTH*PRF_INDEX_SIZE-1:0] dispatch_rs2,
    input  logic [DISPATCH_WIDTH*UOP_WIDTH-1:0]      dispatch_uop,
    output logic                                     dispatch_ready,
    output logic [IQ_SIZE*PRF_INDEX_SIZE-1:0]        rs1_index,
    output logic [IQ_SIZE*PRF_INDEX_SIZE-1:0]        rs2_index,
    input  logic [IQ_SIZE-1:0]                       rs1_busy,
    input  logic [IQ_SIZE-1:0]                       rs2_busy,
    output logic [ISSUE_WIDTH-1:0]                   issue_valid,
    output logic [ISSUE_WIDTH*UOP_WIDTH-1:0]         issue_uop,
    output logic [ISSUE_WIDTH*PRF_INDEX_SIZE-1:0]    issue_rs1,
    output logic [ISSUE_WIDTH*PRF_INDEX_SIZE-1:0]    issue_rs2,
    input  logic [ISSUE_WIDTH-1:0]                   issue_ready,
    output logic [$clog2(IQ_SIZE+1)-1:0]             free_count
);

    localparam int FC_W = $clog2(IQ_SIZE + 1);
    localparam logic [FC_W-1:0]    DW_C   = FC_W'(DISPATCH_WIDTH);
    localparam logic [FC_W-1:0]    SIZE_C = FC_W'(IQ_SIZE);
    localparam logic [IQ_SIZE-1:0] ONE_C  = {{(IQ_SIZE-1){1'b0}}, 1'b1};

    // Number of set bits in a slot vector.
    function automatic logic [FC_W-1:0] count_ones(input logic [IQ_SIZE-1:0] v);
        logic [FC_W-1:0] c;
        c = '0;
        for (int k = 0; k < IQ_SIZE; k++) begin
            c = c + FC_W'(v[k]);
        end
        return c;
    endfunction

    logic [IQ_SIZE-1:0]        valid_r;
    logic [IQ_SIZE-1:0]        valid_n_s;
    logic [PRF_INDEX_SIZE-1:0] rs1_r   [IQ_SIZE];
    logic [PRF_INDEX_SIZE-1:0] rs2_r   [IQ_SIZE];
    logic [UOP_WIDTH-1:0]      uop_r   [IQ_SIZE];
    logic [PRF_INDEX_SIZE-1:0] rs1_n_s [IQ_SIZE];
    logic [PRF_INDEX_SIZE-1:0] rs2_n_s [IQ_SIZE];
    logic [UOP_WIDTH-1:0]      uop_n_s [IQ_SIZE];
    logic [IQ_SIZE-1:0]        older_r   [IQ_SIZE];
    logic [IQ_SIZE-1:0]        older_n_s [IQ_SIZE];
    logic [FC_W-1:0]           free_count_r;
    logic [FC_W-1:0]           free_count_n_s;

    logic                      dispatch_ready_s;
    logic [IQ_SIZE-1:0]        ready_s;
    logic [IQ_SIZE-1:0]        avail_s;
    logic [IQ_SIZE-1:0]        blocked_s;
    logic [IQ_SIZE-1:0]        sel_s   [ISSUE_WIDTH];
    logic [IQ_SIZE-1:0]        issued_s;
    logic [IQ_SIZE-1:0]        free_s;
    logic [IQ_SIZE-1:0]        alloc_s [DISPATCH_WIDTH];
    logic [IQ_SIZE-1:0]        written_s;
    logic [IQ_SIZE-1:0]        keep_s;
    logic [IQ_SIZE-1:0]        group_s;

    // Acceptance is decided from the registered free count only, never from same-cycle issue.
    assign dispatch_ready_s = (free_count_r >= DW_C);
    assign dispatch_ready   = dispatch_ready_s;
    assign free_count       = free_count_r;

    // The scoreboard already applies bypass and x0 rules, so readiness is just "no busy source".
    assign ready_s = valid_r & ~rs1_busy & ~rs2_busy;

    // Scoreboard inquiry: stored source indices, zeroed for empty slots.
    always_comb begin
        rs1_index = '0;
        rs2_index = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            rs1_index[i*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] = rs1_r[i] & {PRF_INDEX_SIZE{valid_r[i]}};
            rs2_index[i*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] = rs2_r[i] & {PRF_INDEX_SIZE{valid_r[i]}};
        end
    end

    // Oldest-first select: each port takes the ready slot with no older ready slot left.
    always_comb begin
        avail_s   = ready_s;
        blocked_s = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            sel_s[p] = '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                blocked_s[i] = 1'b0;
                for (int j = 0; j < IQ_SIZE; j++) begin
                    if (avail_s[j] && older_r[j][i]) begin
                        blocked_s[i] = 1'b1;
                    end else begin
                        blocked_s[i] = blocked_s[i];
                    end
                end
                sel_s[p][i] = avail_s[i] & ~blocked_s[i];
            end
            avail_s = avail_s & ~sel_s[p];
        end
    end

    // Issue port muxing; a slot is released only when its port accepts.
    always_comb begin
        issue_valid = '0;
        issue_uop   = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        issued_s    = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            issue_valid[p] = |sel_s[p];
            for (int i = 0; i < IQ_SIZE; i++) begin
                issue_uop[p*UOP_WIDTH +: UOP_WIDTH] = issue_uop[p*UOP_WIDTH +: UOP_WIDTH]
                    | (uop_r[i] & {UOP_WIDTH{sel_s[p][i]}});
                issue_rs1[p*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] = issue_rs1[p*PRF_INDEX_SIZE +: PRF_INDEX_SIZE]
                    | (rs1_r[i] & {PRF_INDEX_SIZE{sel_s[p][i]}});
                issue_rs2[p*PRF_INDEX_SIZE +: PRF_INDEX_SIZE] = issue_rs2[p*PRF_INDEX_SIZE +: PRF_INDEX_SIZE]
                    | (rs2_r[i] & {PRF_INDEX_SIZE{sel_s[p][i]}});
            end
            if (issue_ready[p]) begin
                issued_s = issued_s | sel_s[p];
            end else begin
                issued_s = issued_s;
            end
        end
    end

    // Slot allocation: accepted lanes take the lowest free slots in lane order.
    // Slots freed by this cycle's issue are not offered until next cycle.
    always_comb begin
        free_s    = ~valid_r;
        written_s = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            rs1_n_s[i] = rs1_r[i];
            rs2_n_s[i] = rs2_r[i];
            uop_n_s[i] = uop_r[i];
        end
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            if (dispatch_valid[w] && dispatch_ready_s) begin
                alloc_s[w] = free_s & (~free_s + ONE_C);
            end else begin
                alloc_s[w] = '0;
            end
            free_s    = free_s & ~alloc_s[w];
            written_s = written_s | alloc_s[w];
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (alloc_s[w][i]) begin
                    rs1_n_s[i] = dispatch_rs1[w*PRF_INDEX_SIZE +: PRF_INDEX_SIZE];
                    rs2_n_s[i] = dispatch_rs2[w*PRF_INDEX_SIZE +: PRF_INDEX_SIZE];
                    uop_n_s[i] = dispatch_uop[w*UOP_WIDTH +: UOP_WIDTH];
                end else begin
                    rs1_n_s[i] = rs1_n_s[i];
                    rs2_n_s[i] = rs2_n_s[i];
                    uop_n_s[i] = uop_n_s[i];
                end
            end
        end
        valid_n_s      = (valid_r & ~issued_s) | written_s;
        free_count_n_s = free_count_r + count_ones(issued_s) - count_ones(written_s);
    end

    // Age matrix update: freed slots drop out, new slots become younger than all survivors
    // and than earlier lanes of the same group.
    always_comb begin
        keep_s  = valid_r & ~issued_s;
        group_s = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (issued_s[i]) begin
                older_n_s[i] = '0;
            end else begin
                older_n_s[i] = older_r[i] & ~issued_s;
            end
        end
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (alloc_s[w][i]) begin
                    older_n_s[i] = '0;
                    for (int j = 0; j < IQ_SIZE; j++) begin
                        older_n_s[j][i] = keep_s[j] | group_s[j];
                    end
                end else begin
                    older_n_s[i] = older_n_s[i];
                end
            end
            group_s = group_s | alloc_s[w];
        end
    end

    // Queue state registers: async reset and synchronous flush both empty the queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r      <= '0;
            free_count_r <= SIZE_C;
            for (int i = 0; i < IQ_SIZE; i++) begin
                older_r[i] <= '0;
                rs1_r[i]   <= '0;
                rs2_r[i]   <= '0;
                uop_r[i]   <= '0;
            end
        end else if (clear) begin
            valid_r      <= '0;
            free_count_r <= SIZE_C;
            for (int i = 0; i < IQ_SIZE; i++) begin
                older_r[i] <= '0;
                rs1_r[i]   <= '0;
                rs2_r[i]   <= '0;
                uop_r[i]   <= '0;
            end
        end else begin
            valid_r      <= valid_n_s;
            free_count_r <= free_count_n_s;
            for (int i = 0; i < IQ_SIZE; i++) begin
                older_r[i] <= older_n_s[i];
                rs1_r[i]   <= rs1_n_s[i];
                rs2_r[i]   <= rs2_n_s[i];
                uop_r[i]   <= uop_n_s[i];
            end
        end
    end

endmodule

// File: doc/issue_queue_int.md
Name: issue_queue_int

Overview:
Integer issue queue sitting between dispatch and the integer execute ports. It sits directly downstream of dispatch and is the consumer of the integer scoreboard's per-slot busy inquiry. It holds dispatched uops, presents each slot's source PRF indices to the scoreboard, and treats a slot as ready when both returned busy bits are 0. Each cycle it selects up to ISSUE_WIDTH oldest ready uops and issues them with a valid/ready handshake.

Parameters:
IQ_SIZE, 8, number of slots (≥ ISSUE_WIDTH, ≥ DISPATCH_WIDTH)
DISPATCH_WIDTH, 2, uops accepted per cycle
ISSUE_WIDTH, 2, issue ports
PRF_INDEX_SIZE, 6, physical register index width
UOP_WIDTH, 64, opaque payload width (opcode, rd, imm, rob id)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
clear  in  1  synchronous flush (mispredict/exception)
dispatch_valid  in  DISPATCH_WIDTH  per-lane uop valid
dispatch_rs1  in  DISPATCH_WIDTH×PRF_INDEX_SIZE  source-1 PRF index
dispatch_rs2  in  DISPATCH_WIDTH×PRF_INDEX_SIZE  source-2 PRF index
dispatch_uop  in  DISPATCH_WIDTH×UOP_WIDTH  payload
dispatch_ready  out  1  queue can accept a full dispatch group this cycle
rs1_index  out  IQ_SIZE×PRF_INDEX_SIZE  per-slot rs1 to scoreboard
rs2_index  out  IQ_SIZE×PRF_INDEX_SIZE  per-slot rs2 to scoreboard
rs1_busy  in  IQ_SIZE  scoreboard reply, same cycle
rs2_busy  in  IQ_SIZE  scoreboard reply, same cycle
issue_valid  out  ISSUE_WIDTH  port p carries a uop
issue_uop  out  ISSUE_WIDTH×UOP_WIDTH  issued payload
issue_rs1  out  ISSUE_WIDTH×PRF_INDEX_SIZE  for PRF read
issue_rs2  out  ISSUE_WIDTH×PRF_INDEX_SIZE  for PRF read
issue_ready  in  ISSUE_WIDTH  port p accepts
free_count  out  $clog2(IQ_SIZE+1)  registered count of empty slots

Behaviour:
- Per-slot state: valid, rs1, rs2, uop, plus an IQ_SIZE×IQ_SIZE age matrix (older[i][j] = slot i dispatched before slot j).
- Reset (reset=0, async): all valid=0, age matrix=0, free_count=IQ_SIZE. Outputs during and after reset: issue_valid=0, issue_uop/rs1/rs2=0, dispatch_ready=1, rs*_index=0.
- clear=1 at a clock edge: same effect as reset, synchronous. Clear overrides a same-cycle dispatch and issue; no slot is written and nothing counts as issued.
- dispatch_ready = (free_count ≥ DISPATCH_WIDTH), from registered state only. It never depends on same-cycle issue.
- Dispatch acceptance: a lane w is accepted when dispatch_valid[w] & dispatch_ready.
  - Accepted lanes fill the lowest-indexed free slots in lane order. Valid lanes may be non-contiguous.
  - A new slot is written at the edge. It is marked younger than every existing valid slot. Lane w is older than lane w+1 of the same group.
- Scoreboard interface: rs*_index[i] = stored index of slot i, or 0 when the slot is invalid.
- Readiness: slot i is ready = valid[i] & ~rs1_busy[i] & ~rs2_busy[i].
  - The scoreboard performs the write-back bypass and x0 handling; the queue adds no wakeup logic.
  - A uop dispatched at edge t is first eligible in cycle t+1, using the scoreboard state after its set_busy.
- Selection (combinational):
  - Port 0 gets the oldest ready slot. Port p gets the oldest ready slot not chosen by ports < p.
  - issue_valid[p]=1 iff a slot was chosen. Payload and indices come from that slot.
  - issue_valid must not depend on issue_ready.
- Issue completion: if issue_valid[p] & issue_ready[p] at the edge, the chosen slot's valid is cleared.
  - When a port stalls, its slot stays valid and may be re-selected next cycle, possibly on another port.
- free_count next = free_count + issued − accepted.
  - Slots freed this cycle are reusable from the next cycle.
  - Dispatch and issue in the same cycle are both honoured.
- No valid slot ever holds an index that is not from an accepted dispatch.
- Full (free_count=0): dispatch_ready=0 and issue proceeds normally. Empty: issue_valid=0.
- Age-matrix updates:
  - On freeing slot i, clear row i and column i.
  - On writing slot i, set column i for all currently valid slots and for earlier lanes of the same group, and clear row i.

Test Plan:
1. Reset → free_count=8, dispatch_ready=1, issue_valid=00. Dispatch two uops with rs1/rs2=0 → next cycle issue_valid=11; uop from lane 0 on port 0.
2. Dependency: dispatch A (rs1=5), scoreboard drives rs1_busy=1 for 3 cycles, then 0 → A issues exactly in the cycle busy drops, not before.
3. Fill 8 slots, all busy → dispatch_ready=0, free_count=0. Release one and accept it (issue_ready=1) → next cycle free_count=1, dispatch_ready still 0. Release a second → dispatch_ready=1.
4. Age order: dispatch C, D, E; make E then C ready in that order → C still issues on port 0 ahead of E once both are ready.
5. Backpressure: issue_ready=00 with 2 ready slots for 4 cycles → same uops held, free_count unchanged. issue_ready=01 → only port-0 slot freed.
6. Flush/reset mid-operation: clear=1 while dispatch_valid=11 and issue_ready=11 → free_count=8, no uop retained. Assert reset=0 between edges → issue_valid=0 immediately.
